// File: rtl/client_acquire_lock_arbiter.sv
// Two-requester round-robin TileLink acquire arbiter that holds the winner for a
// full PutBlock burst, and routes grants back by client_xact_id bit 1.
module client_acquire_lock_arbiter #(
   parameter int unsigned BEATS         = 8,
   parameter logic [2:0]  PUTBLOCK_TYPE = 3'h3
) (
   input  logic        clk,
   input  logic        reset,
   output logic        io_in_0_acquire_ready,
   input  logic        io_in_0_acquire_valid,
   input  logic [25:0] io_in_0_acquire_bits_addr_block,
   input  logic        io_in_0_acquire_bits_client_xact_id,
   input  logic [2:0]  io_in_0_acquire_bits_addr_beat,
   input  logic        io_in_0_acquire_bits_is_builtin_type,
   input  logic [2:0]  io_in_0_acquire_bits_a_type,
   input  logic [11:0] io_in_0_acquire_bits_union,
   input  logic [63:0] io_in_0_acquire_bits_data,
   output logic        io_in_1_acquire_ready,
   input  logic        io_in_1_acquire_valid,
   input  logic [25:0] io_in_1_acquire_bits_addr_block,
   input  logic        io_in_1_acquire_bits_client_xact_id,
   input  logic [2:0]  io_in_1_acquire_bits_addr_beat,
   input  logic        io_in_1_acquire_bits_is_builtin_type,
   input  logic [2:0]  io_in_1_acquire_bits_a_type,
   input  logic [11:0] io_in_1_acquire_bits_union,
   input  logic [63:0] io_in_1_acquire_bits_data,
   input  logic        io_out_acquire_ready,
   output logic        io_out_acquire_valid,
   output logic [25:0] io_out_acquire_bits_addr_block,
   output logic [1:0]  io_out_acquire_bits_client_xact_id,
   output logic [2:0]  io_out_acquire_bits_addr_beat,
   output logic        io_out_acquire_bits_is_builtin_type,
   output logic [2:0]  io_out_acquire_bits_a_type,
   output logic [11:0] io_out_acquire_bits_union,
   output logic [63:0] io_out_acquire_bits_data,
   output logic        io_out_grant_ready,
   input  logic        io_out_grant_valid,
   input  logic [1:0]  io_out_grant_bits_client_xact_id,
   input  logic [2:0]  io_out_grant_bits_addr_beat,
   input  logic [1:0]  io_out_grant_bits_manager_xact_id,
   input  logic        io_out_grant_bits_is_builtin_type,
   input  logic [3:0]  io_out_grant_bits_g_type,
   input  logic [63:0] io_out_grant_bits_data,
   input  logic        io_out_grant_bits_manager_id,
   input  logic        io_in_0_grant_ready,
   output logic        io_in_0_grant_valid,
   output logic        io_in_0_grant_bits_client_xact_id,
   output logic [2:0]  io_in_0_grant_bits_addr_beat,
   output logic [1:0]  io_in_0_grant_bits_manager_xact_id,
   output logic        io_in_0_grant_bits_is_builtin_type,
   output logic [3:0]  io_in_0_grant_bits_g_type,
   output logic [63:0] io_in_0_grant_bits_data,
   output logic        io_in_0_grant_bits_manager_id,
   input  logic        io_in_1_grant_ready,
   output logic        io_in_1_grant_valid,
   output logic        io_in_1_grant_bits_client_xact_id,
   output logic [2:0]  io_in_1_grant_bits_addr_beat,
   output logic [1:0]  io_in_1_grant_bits_manager_xact_id,
   output logic        io_in_1_grant_bits_is_builtin_type,
   output logic [3:0]  io_in_1_grant_bits_g_type,
   output logic [63:0] io_in_1_grant_bits_data,
   output logic        io_in_1_grant_bits_manager_id
);

   typedef struct packed {
      logic [25:0] addr_block;
      logic        xact_id;
      logic [2:0]  addr_beat;
      logic        is_builtin_type;
      logic [2:0]  a_type;
      logic [11:0] un;
      logic [63:0] data;
   } acq_t;

   typedef enum logic {S_OPEN = 1'b0, S_LOCKED = 1'b1} state_t;

   localparam logic [2:0] LAST_BEAT = 3'(BEATS - 1);

   state_t      r_state, w_state_nxt;
   logic        r_lock_idx, w_lock_idx_nxt;
   logic [2:0]  r_beat_cnt, w_beat_cnt_nxt;
   logic        r_last_idx, w_last_idx_nxt;

   logic [1:0]  w_in_valid;
   acq_t [1:0]  w_in_acq;
   acq_t        w_sel_acq;
   logic        w_winner;
   logic        w_sel_valid;
   logic        w_multibeat;
   logic        w_fire;
   logic        w_gsel;

   assign w_in_valid  = {io_in_1_acquire_valid, io_in_0_acquire_valid};
   assign w_in_acq[0] = {io_in_0_acquire_bits_addr_block, io_in_0_acquire_bits_client_xact_id,
                         io_in_0_acquire_bits_addr_beat, io_in_0_acquire_bits_is_builtin_type,
                         io_in_0_acquire_bits_a_type, io_in_0_acquire_bits_union,
                         io_in_0_acquire_bits_data};
   assign w_in_acq[1] = {io_in_1_acquire_bits_addr_block, io_in_1_acquire_bits_client_xact_id,
                         io_in_1_acquire_bits_addr_beat, io_in_1_acquire_bits_is_builtin_type,
                         io_in_1_acquire_bits_a_type, io_in_1_acquire_bits_union,
                         io_in_1_acquire_bits_data};

   // With nobody valid this falls to port 0, which is also the idle mux choice.
   assign w_winner    = (r_state == S_LOCKED) ? r_lock_idx :
                        (&w_in_valid)         ? ~r_last_idx : w_in_valid[1];
   assign w_sel_acq   = w_in_acq[w_winner];
   assign w_sel_valid = w_in_valid[w_winner] & ~reset;
   assign w_multibeat = w_sel_acq.is_builtin_type & (w_sel_acq.a_type == PUTBLOCK_TYPE);
   assign w_fire      = w_sel_valid & io_out_acquire_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_OPEN;
         r_lock_idx <= 1'b0;
         r_beat_cnt <= 3'd0;
         r_last_idx <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_lock_idx <= w_lock_idx_nxt;
         r_beat_cnt <= w_beat_cnt_nxt;
         r_last_idx <= w_last_idx_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_lock_idx_nxt = r_lock_idx;
      w_beat_cnt_nxt = r_beat_cnt;
      w_last_idx_nxt = r_last_idx;
      if (w_fire) begin
         case (r_state)
            S_OPEN: begin
               w_last_idx_nxt = w_winner;
               if (w_multibeat) begin
                  w_state_nxt    = S_LOCKED;
                  w_lock_idx_nxt = w_winner;
                  w_beat_cnt_nxt = 3'd1;
               end
            end
            S_LOCKED: begin
               w_beat_cnt_nxt = r_beat_cnt + 3'd1;
               if (r_beat_cnt == LAST_BEAT) w_state_nxt = S_OPEN;
            end
            default: w_state_nxt = S_OPEN;
         endcase
      end
   end

   assign io_in_0_acquire_ready = ~reset & io_out_acquire_ready & ~w_winner;
   assign io_in_1_acquire_ready = ~reset & io_out_acquire_ready &  w_winner;

   assign io_out_acquire_valid                = w_sel_valid;
   assign io_out_acquire_bits_addr_block      = w_sel_acq.addr_block;
   assign io_out_acquire_bits_client_xact_id  = {w_winner, w_sel_acq.xact_id};
   assign io_out_acquire_bits_addr_beat       = w_sel_acq.addr_beat;
   assign io_out_acquire_bits_is_builtin_type = w_sel_acq.is_builtin_type;
   assign io_out_acquire_bits_a_type          = w_sel_acq.a_type;
   assign io_out_acquire_bits_union           = w_sel_acq.un;
   assign io_out_acquire_bits_data            = w_sel_acq.data;

   // Grant return path: bit 1 of the echoed xact id is the requester index.
   assign w_gsel              = io_out_grant_bits_client_xact_id[1];
   assign io_in_0_grant_valid = ~reset & io_out_grant_valid & ~w_gsel;
   assign io_in_1_grant_valid = ~reset & io_out_grant_valid &  w_gsel;
   assign io_out_grant_ready  = ~reset & (w_gsel ? io_in_1_grant_ready : io_in_0_grant_ready);

   assign io_in_0_grant_bits_client_xact_id  = io_out_grant_bits_client_xact_id[0];
   assign io_in_0_grant_bits_addr_beat       = io_out_grant_bits_addr_beat;
   assign io_in_0_grant_bits_manager_xact_id = io_out_grant_bits_manager_xact_id;
   assign io_in_0_grant_bits_is_builtin_type = io_out_grant_bits_is_builtin_type;
   assign io_in_0_grant_bits_g_type          = io_out_grant_bits_g_type;
   assign io_in_0_grant_bits_data            = io_out_grant_bits_data;
   assign io_in_0_grant_bits_manager_id      = io_out_grant_bits_manager_id;
   assign io_in_1_grant_bits_client_xact_id  = io_out_grant_bits_client_xact_id[0];
   assign io_in_1_grant_bits_addr_beat       = io_out_grant_bits_addr_beat;
   assign io_in_1_grant_bits_manager_xact_id = io_out_grant_bits_manager_xact_id;
   assign io_in_1_grant_bits_is_builtin_type = io_out_grant_bits_is_builtin_type;
   assign io_in_1_grant_bits_g_type          = io_out_grant_bits_g_type;
   assign io_in_1_grant_bits_data            = io_out_grant_bits_data;
   assign io_in_1_grant_bits_manager_id      = io_out_grant_bits_manager_id;

endmodule
